// File: rtl/ps2_pkg.sv
// Shared constants, frame state encoding and byte classification for the PS/2 key decoder.
package ps2_pkg;

    localparam logic [7:0] PS2_EXT    = 8'hE0;
    localparam logic [7:0] PS2_REL    = 8'hF0;
    localparam logic [7:0] PS2_PAUSE  = 8'hE1;

    localparam logic [7:0] PS2_ACK    = 8'hFA;
    localparam logic [7:0] PS2_BAT    = 8'hAA;
    localparam logic [7:0] PS2_ECHO   = 8'hEE;
    localparam logic [7:0] PS2_RESEND = 8'hFE;
    localparam logic [7:0] PS2_OVR0   = 8'h00;
    localparam logic [7:0] PS2_OVR1   = 8'hFF;

    localparam int FRAME_BITS = 11;

    typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} frame_state_e;

    // Keyboard housekeeping replies that never represent a key.
    function automatic logic is_ignore_code(input logic [7:0] b);
        return (b == PS2_ACK) || (b == PS2_BAT) || (b == PS2_ECHO) ||
               (b == PS2_RESEND) || (b == PS2_OVR0) || (b == PS2_OVR1);
    endfunction

endpackage

// File: rtl/ps2_frame_rx.sv
// PS/2 line receiver: 2-FF synchronisers, clock glitch filter, 11-bit frame FSM and timeout.
// byte_valid_o / err_o are single-cycle strobes in the cycle the stop bit is sampled (or timeout fires).
module ps2_frame_rx
    import ps2_pkg::*;
#(
    parameter int FILTER_LEN     = 8,
    parameter int TIMEOUT_CYCLES = 8000
) (
    input  logic       clk_i,
    input  logic       reset_i,
    input  logic       ps2_clk_i,
    input  logic       ps2_data_i,
    output logic [7:0] byte_o,
    output logic       byte_valid_o,
    output logic       err_o
);

    localparam int DATA_BITS = FRAME_BITS - 3;
    localparam int FW = $clog2(FILTER_LEN + 1);
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [FW-1:0] FLT_LAST = FW'(FILTER_LEN - 1);
    localparam logic [TW-1:0] TO_LAST  = TW'(TIMEOUT_CYCLES - 1);
    localparam logic [2:0]    BIT_LAST = 3'(DATA_BITS - 1);

    logic          clk_meta_q, clk_sync_q, data_meta_q, data_sync_q;
    logic          filt_q, filt_d;
    logic [FW-1:0] fcnt_q, fcnt_d;
    frame_state_e  state_q, state_d;
    logic [2:0]    bitcnt_q, bitcnt_d;
    logic [7:0]    shift_q, shift_d;
    logic          par_q, par_d;
    logic [TW-1:0] tcnt_q, tcnt_d;
    logic          fall;

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            clk_meta_q  <= 1'b1;
            clk_sync_q  <= 1'b1;
            data_meta_q <= 1'b1;
            data_sync_q <= 1'b1;
            filt_q      <= 1'b1;
            fcnt_q      <= '0;
            state_q     <= IDLE;
            bitcnt_q    <= '0;
            shift_q     <= '0;
            par_q       <= 1'b0;
            tcnt_q      <= '0;
        end else begin
            clk_meta_q  <= ps2_clk_i;
            clk_sync_q  <= clk_meta_q;
            data_meta_q <= ps2_data_i;
            data_sync_q <= data_meta_q;
            filt_q      <= filt_d;
            fcnt_q      <= fcnt_d;
            state_q     <= state_d;
            bitcnt_q    <= bitcnt_d;
            shift_q     <= shift_d;
            par_q       <= par_d;
            tcnt_q      <= tcnt_d;
        end
    end

    // Any sample matching the filtered level restarts the run of differing samples.
    always_comb begin
        filt_d = filt_q;
        fcnt_d = '0;
        if (clk_sync_q != filt_q) begin
            if (fcnt_q == FLT_LAST) filt_d = clk_sync_q;
            else                    fcnt_d = fcnt_q + FW'(1);
        end
    end

    assign fall = filt_q & ~filt_d;

    always_comb begin
        state_d      = state_q;
        bitcnt_d     = bitcnt_q;
        shift_d      = shift_q;
        par_d        = par_q;
        tcnt_d       = '0;
        byte_valid_o = 1'b0;
        err_o        = 1'b0;
        // Timeout takes priority over an edge arriving in the same cycle.
        if (state_q != IDLE && tcnt_q == TO_LAST) begin
            state_d = IDLE;
            err_o   = 1'b1;
        end else begin
            if (state_q != IDLE && !fall) tcnt_d = tcnt_q + TW'(1);
            if (fall) begin
                case (state_q)
                    IDLE: if (!data_sync_q) begin
                        state_d  = DATA;
                        bitcnt_d = '0;
                    end
                    DATA: begin
                        shift_d = {data_sync_q, shift_q[7:1]};
                        if (bitcnt_q == BIT_LAST) state_d = PARITY;
                        else                      bitcnt_d = bitcnt_q + 3'd1;
                    end
                    PARITY: begin
                        par_d   = data_sync_q;
                        state_d = STOP;
                    end
                    STOP: begin
                        state_d = IDLE;
                        if ((^shift_q ^ par_q) && data_sync_q) byte_valid_o = 1'b1;
                        else                                   err_o        = 1'b1;
                    end
                    default: state_d = IDLE;
                endcase
            end
        end
    end

    assign byte_o = shift_q;

endmodule

// File: rtl/ps2_key_decoder.sv
// PS/2 keyboard front end: turns received bytes into toggle-strobed make/break events on ps2_key.
// Optional macro PS2_E1_FILTER_EN swallows the whole Pause (E1 ...) sequence.
module ps2_key_decoder
    import ps2_pkg::*;
#(
    parameter int FILTER_LEN     = 8,
    parameter int TIMEOUT_CYCLES = 8000
) (
    input  logic        clk_sys,
    input  logic        reset,
    input  logic        ps2_clk,
    input  logic        ps2_data,
    output logic [10:0] ps2_key,
    output logic        frame_err
);

    logic [7:0]  rx_byte;
    logic        rx_valid, rx_err;
    logic [10:0] key_q, key_d;
    logic        err_q, ext_q, ext_d, rel_q, rel_d;
`ifdef PS2_E1_FILTER_EN
    logic [2:0]  skip_q, skip_d;
`endif

    ps2_frame_rx #(
        .FILTER_LEN    (FILTER_LEN),
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_rx (
        .clk_i       (clk_sys),
        .reset_i     (reset),
        .ps2_clk_i   (ps2_clk),
        .ps2_data_i  (ps2_data),
        .byte_o      (rx_byte),
        .byte_valid_o(rx_valid),
        .err_o       (rx_err)
    );

    always_ff @(posedge clk_sys or posedge reset) begin
        if (reset) begin
            key_q  <= '0;
            err_q  <= 1'b0;
            ext_q  <= 1'b0;
            rel_q  <= 1'b0;
`ifdef PS2_E1_FILTER_EN
            skip_q <= '0;
`endif
        end else begin
            key_q  <= key_d;
            err_q  <= rx_err;
            ext_q  <= ext_d;
            rel_q  <= rel_d;
`ifdef PS2_E1_FILTER_EN
            skip_q <= skip_d;
`endif
        end
    end

    always_comb begin
        key_d = key_q;
        ext_d = ext_q;
        rel_d = rel_q;
`ifdef PS2_E1_FILTER_EN
        skip_d = skip_q;
        if (rx_err) begin
            skip_d = '0;
        end else if (rx_valid && skip_q != '0) begin
            skip_d = skip_q - 3'd1;
        end else if (rx_valid && rx_byte == PS2_PAUSE && !ext_q && !rel_q) begin
            skip_d = 3'd7;
        end
`endif
        if (rx_err) begin
            ext_d = 1'b0;
            rel_d = 1'b0;
        end else if (rx_valid
`ifdef PS2_E1_FILTER_EN
                     && skip_q == '0
`endif
                    ) begin
            // Pause prefix is always dropped; ignore codes only count when no prefix is pending.
            if (rx_byte == PS2_REL) begin
                rel_d = 1'b1;
            end else if (rx_byte == PS2_EXT) begin
                ext_d = 1'b1;
            end else if (rx_byte != PS2_PAUSE &&
                         !(!ext_q && !rel_q && is_ignore_code(rx_byte))) begin
                key_d = {~key_q[10], ~rel_q, ext_q, rx_byte};
                ext_d = 1'b0;
                rel_d = 1'b0;
            end
        end
    end

    assign ps2_key   = key_q;
    assign frame_err = err_q;

endmodule

// File: tb/tb_ps2_key_decoder.sv
// Directed plus randomized bench for ps2_key_decoder with a byte-level reference model.
module tb_ps2_key_decoder;

    localparam int FILTER_LEN     = 8;
    localparam int TIMEOUT_CYCLES = 8000;
    localparam int LAT            = 2 + FILTER_LEN;
    localparam int SLOW_HALF      = 320;
    localparam int FAST_HALF      = 40;

    logic        clk_sys = 1'b0;
    logic        reset   = 1'b1;
    logic        ps2_clk = 1'b1;
    logic        ps2_data = 1'b1;
    logic [10:0] ps2_key;
    logic        frame_err;

    int tests_run = 0;
    int tests_failed = 0;
    int err_seen = 0;
    int toggles = 0;
    int lat_key, lat_err;
    logic prev_strobe = 1'b0;

    logic [10:0] m_key = '0;
    bit m_ext = 0, m_rel = 0;
    int m_skip = 0;

    ps2_key_decoder #(
        .FILTER_LEN    (FILTER_LEN),
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) dut (
        .clk_sys  (clk_sys),
        .reset    (reset),
        .ps2_clk  (ps2_clk),
        .ps2_data (ps2_data),
        .ps2_key  (ps2_key),
        .frame_err(frame_err)
    );

    always #5 clk_sys = ~clk_sys;

    always @(negedge clk_sys) begin
        if (frame_err === 1'b1) err_seen++;
        if (ps2_key[10] !== prev_strobe) toggles++;
        prev_strobe = ps2_key[10];
    end

    initial begin
        #5000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic cyc(input int n);
        repeat (n) @(negedge clk_sys);
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests_run++;
        assert (obs === exp) else begin
            tests_failed++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Reference model: key events derived from the byte stream.
    task automatic model_byte(input logic [7:0] b);
`ifdef PS2_E1_FILTER_EN
        if (m_skip > 0) begin
            m_skip--;
            return;
        end
`endif
        if (b == 8'hF0) m_rel = 1;
        else if (b == 8'hE0) m_ext = 1;
        else if (b == 8'hE1) begin
`ifdef PS2_E1_FILTER_EN
            if (!m_ext && !m_rel) m_skip = 7;
`endif
        end else if (!m_ext && !m_rel && (b inside {8'hFA, 8'hAA, 8'hEE, 8'hFE, 8'h00, 8'hFF})) begin
        end else begin
            m_key = {~m_key[10], ~m_rel, m_ext, b};
            m_ext = 0;
            m_rel = 0;
        end
    endtask

    task automatic model_err();
        m_ext = 0;
        m_rel = 0;
        m_skip = 0;
    endtask

    // Drive the first nbits of an 11-bit frame; measure event/error latency after the stop-bit fall.
    task automatic send_frame(input logic [7:0] b, input bit flip_par, input int half,
                              input bit glitch, input int nbits);
        logic [10:0] bits;
        logic [10:0] k0;
        bits = {1'b1, (~^b) ^ flip_par, b, 1'b0};
        k0 = ps2_key;
        lat_key = -1;
        lat_err = -1;
        for (int i = 0; i < nbits; i++) begin
            ps2_data = bits[i];
            cyc(half / 2);
            if (glitch && i == 4) begin
                ps2_clk = 1'b0; cyc(2); ps2_clk = 1'b1;
            end
            cyc(half / 2);
            ps2_clk = 1'b0;
            if (i == 10) begin
                for (int c = 1; c <= half; c++) begin
                    cyc(1);
                    if (lat_key < 0 && ps2_key !== k0) lat_key = c;
                    if (lat_err < 0 && frame_err === 1'b1) lat_err = c;
                end
            end else begin
                cyc(half / 2);
                if (glitch && i == 4) begin
                    ps2_clk = 1'b1; cyc(2); ps2_clk = 1'b0;
                end
                cyc(half / 2);
            end
            ps2_clk = 1'b1;
        end
        ps2_data = 1'b1;
        cyc(100);
    endtask

    task automatic send_byte(input logic [7:0] b, input bit flip, input int half,
                             input bit glitch, input string tag);
        int e0;
        e0 = err_seen;
        send_frame(b, flip, half, glitch, 11);
        if (flip) model_err();
        else      model_byte(b);
        chk({tag, "_key"}, 32'(ps2_key), 32'(m_key));
        chk({tag, "_err"}, 32'(err_seen - e0), flip ? 32'd1 : 32'd0);
    endtask

    initial begin
        int e0, t0;
        logic [7:0] b;
        logic [7:0] pause_seq [8];

        reset = 1'b1;
        cyc(3);
        chk("reset_key", 32'(ps2_key), 32'h000);
        chk("reset_err", 32'(frame_err), 32'd0);
        reset = 1'b0;
        cyc(20);

        // 1C at 12.5 kHz; strobe 0->1 one cycle after the stop sample.
        send_byte(8'h1C, 0, SLOW_HALF, 0, "slow_1c");
        chk("slow_1c_exact", 32'(ps2_key), 32'h61C);
        chk("slow_1c_lat", 32'(lat_key), 32'(LAT));

        t0 = toggles;
        send_byte(8'hF0, 0, FAST_HALF, 0, "brk_f0");
        send_byte(8'h1C, 0, FAST_HALF, 0, "brk_1c");
        chk("brk_bits", 32'(ps2_key[9:0]), 32'h01C);
        chk("brk_toggles", 32'(toggles - t0), 32'd1);

        send_byte(8'hE0, 0, FAST_HALF, 0, "ext_e0");
        send_byte(8'hF0, 0, FAST_HALF, 0, "ext_f0");
        send_byte(8'h75, 0, FAST_HALF, 0, "ext_75");
        chk("ext_brk_bits", 32'(ps2_key[9:0]), 32'h175);
        send_byte(8'h75, 0, FAST_HALF, 0, "plain_75");
        chk("plain_bits", 32'(ps2_key[9:0]), 32'h275);

        send_byte(8'h1C, 1, FAST_HALF, 0, "par_err");
        chk("par_err_lat", 32'(lat_err), 32'(LAT));
        chk("par_key_hold", 32'(lat_key), 32'hFFFF_FFFF);
        send_byte(8'h1C, 0, FAST_HALF, 0, "after_par");

        // Abandon a frame after 4 data bits and let the timeout recover.
        e0 = err_seen;
        send_frame(8'h5A, 0, FAST_HALF, 0, 5);
        cyc(TIMEOUT_CYCLES + 100);
        model_err();
        chk("timeout_err", 32'(err_seen - e0), 32'd1);
        chk("timeout_key", 32'(ps2_key), 32'(m_key));
        send_byte(8'h32, 0, FAST_HALF, 0, "after_to");
        chk("after_to_bits", 32'(ps2_key[9:0]), 32'h232);

        send_byte(8'hA5, 0, FAST_HALF, 1, "glitch");

        send_byte(8'hFA, 0, FAST_HALF, 0, "ack_ign");
        send_byte(8'hAA, 0, FAST_HALF, 0, "bat_ign");

        pause_seq = '{8'hE1, 8'h14, 8'h77, 8'hE1, 8'hF0, 8'h14, 8'hF0, 8'h77};
        t0 = toggles;
        for (int i = 0; i < 8; i++) send_byte(pause_seq[i], 0, FAST_HALF, 0, "pause");
`ifdef PS2_E1_FILTER_EN
        chk("pause_events", 32'(toggles - t0), 32'd0);
`else
        chk("pause_events", 32'(toggles - t0), 32'd4);
`endif

        for (int n = 0; n < 16; n++) begin
            case ($urandom_range(0, 9))
                0: b = 8'hE0;
                1: b = 8'hF0;
                2: b = 8'hE1;
                3: b = 8'hFE;
                default: b = 8'($urandom_range(0, 255));
            endcase
            send_byte(b, ($urandom_range(0, 7) == 0), FAST_HALF, 0, "rand");
        end

        // Reset in the middle of a frame: no event, no error, state cleared.
        t0 = toggles;
        e0 = err_seen;
        send_frame(8'h3C, 0, FAST_HALF, 0, 6);
        reset = 1'b1;
        cyc(3);
        reset = 1'b0;
        m_key = '0;
        model_err();
        cyc(20);
        chk("midrst_key", 32'(ps2_key), 32'h000);
        chk("midrst_err", 32'(err_seen - e0), 32'd0);
        send_byte(8'h1C, 0, FAST_HALF, 0, "post_rst");
        chk("post_rst_exact", 32'(ps2_key), 32'h61C);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/ps2_key_decoder.md
Name: ps2_key_decoder

Overview:
- PS/2 keyboard receiver that sits directly upstream of the computer core.
- Converts raw ps2_clk/ps2_data line activity into the 11-bit ps2_key event bus, which the core's keyboard matrix consumes.
- Handles line synchronisation, glitch filtering, 11-bit frame capture, parity/stop checking, timeout recovery and E0/F0 prefix decoding.
- Emits one toggle-strobed event per completed make or break code.

Parameters:
- FILTER_LEN, 8: consecutive identical synchronised samples required before the filtered ps2_clk changes level.
- TIMEOUT_CYCLES, 8000: clk_sys cycles without a filtered falling edge before a partial frame is aborted (1 ms at 8 MHz).

Ports:
- clk_sys  in  1  system clock, 8 MHz.
- reset  in  1  asynchronous, active-high reset.
- ps2_clk  in  1  raw PS/2 clock line, asynchronous.
- ps2_data  in  1  raw PS/2 data line, asynchronous.
- ps2_key  out  11  [10] toggle strobe, [9] pressed (1 = make), [8] extended (E0 seen), [7:0] scan code.
- frame_err  out  1  one-cycle pulse on a parity, stop or timeout error.

Behaviour:
- Reset is asynchronous, active-high; the clock is clk_sys.
- Reset values: ps2_key = 11'h000, frame_err = 0, bit counter = 0, prefix flags ext = rel = 0, filtered clock = 1, timeout counter = 0.
- Input sync: both lines pass through a 2-FF synchroniser.
- Clock filter: filtered clock changes only after FILTER_LEN equal consecutive samples that differ from its current value. A falling edge is the cycle the filtered clock goes 1->0. Data is sampled from the synchronised ps2_data in that same cycle.
- Frame FSM states:
  - IDLE: on a falling edge, if data = 0 (start bit), go to DATA with bitcnt = 0. If data = 1, stay in IDLE with no error.
  - DATA: shift data LSB-first on each falling edge. After the 8th bit, go to PARITY.
  - PARITY: capture the parity bit, go to STOP.
  - STOP: capture the stop bit, go to IDLE. The byte is valid only if parity is odd over 8 data bits + parity and stop = 1. Otherwise pulse frame_err, discard the byte, and clear ext/rel.
- Timeout: in any state other than IDLE, a counter increments each cycle without a falling edge and is cleared on each falling edge. When it reaches TIMEOUT_CYCLES-1: return to IDLE, pulse frame_err, clear ext/rel.
- Byte decode, applied to each valid byte in the cycle after the stop-bit sample:
  - F0: rel <= 1, no event.
  - E0: ext <= 1, no event.
  - FA, AA, EE, FE, 00, FF with ext = rel = 0: ignored (ack/BAT/echo/resend/overrun).
  - Any other byte: ps2_key <= {~ps2_key[10], ~rel, ext, byte}, then ext <= 0 and rel <= 0.
- Latency: ps2_key changes exactly 1 clk_sys cycle after the cycle in which the stop bit is sampled. frame_err pulses in that same cycle for parity/stop errors.
- Events never coalesce: PS/2 frames are at least ~600 clk_sys cycles apart.
- Reset mid-frame aborts the frame. No event is emitted and the strobe does not toggle.
- A falling edge arriving in the same cycle the timeout fires: the timeout wins, and the edge is ignored.

Optional Feature:
- Macro: PS2_E1_FILTER_EN.
- Defined: an E1 byte received with no prefix pending arms a 3-bit skip counter. The next 7 valid bytes (rest of the Pause sequence 14 77 E1 F0 14 F0 77) are discarded with no events. A frame error clears the skip counter.
- Undefined: E1 is dropped as a single byte, and the following bytes decode normally (emitting make 14, make 77, break 14, break 77).

Decomposition:
- Package ps2_pkg:
  - prefix constants PS2_EXT = 8'hE0, PS2_REL = 8'hF0, PS2_PAUSE = 8'hE1;
  - ignore-code constants;
  - frame FSM state enum (IDLE, DATA, PARITY, STOP);
  - FRAME_BITS = 11.
- Sub-module ps2_frame_rx: synchroniser, filter, frame FSM and timeout. Outputs byte, byte_valid and err pulses.
- Top level ps2_key_decoder: prefix/skip logic and the ps2_key register.

Test Plan:
- Frame for 1C (data bits 0,0,1,1,1,0,0,0, parity 0, stop 1) at 12.5 kHz -> ps2_key = {1,1,0,8'h1C} (strobe 0->1), 1 cycle after the stop sample; frame_err stays 0.
- Bytes F0,1C -> one event only, ps2_key[9:0] = {0,0,8'h1C}, strobe toggles once.
- Bytes E0,F0,75 -> ps2_key[9:0] = {0,1,8'h75}. A following 75 -> {1,0,8'h75}, confirming the flags cleared.
- 1C frame with parity bit flipped -> frame_err pulses one cycle, ps2_key unchanged. The next valid 1C decodes normally.
- Stop after 4 data bits for 8000 cycles -> frame_err pulse at the timeout, FSM returns to IDLE. A following valid 32 frame yields {1,0,8'h32}.
- 2-cycle glitch pulses on ps2_clk mid-frame (FILTER_LEN = 8) -> ignored, byte decodes correctly. With PS2_E1_FILTER_EN, the Pause sequence yields zero events.
